// File: rtl/bcd_pkg.sv
// Shared 7-segment constants and the BCD-to-segment decode used by the display blocks.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package bcd_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Codes 10..15 are not BCD and show a dash so bad upstream data is visible.
    function automatic logic [6:0] bcd_to_seg(input logic [BCD_W-1:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational single-digit BCD to 7-segment decoder, reusable by any display block.
module bcd_to_seg7
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    output logic [6:0]       o_seg
);

    assign o_seg = bcd_to_seg(i_bcd);

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed BCD display driver: snapshots packed digits once per frame and
// scans them onto a shared 7-segment bus with one-hot digit enables.
module bcd_scan_display
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
    input  logic                        load,
    input  logic                        blank_lz,
    output logic [6:0]                  seg,
    output logic [NUM_DIGITS-1:0]       an,
    output logic                        frame_done
);

    localparam int PS_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW    = BCD_W * NUM_DIGITS;

    logic [PS_W-1:0]       r_prescaler;
    logic [IDX_W-1:0]      r_index;
    logic [DW-1:0]         r_shadow;
    logic [DW-1:0]         r_disp;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_frame_done;

    logic                  w_tc;
    logic                  w_wrap;
    logic [BCD_W-1:0]      w_sel_digit;
    logic [6:0]            w_seg_dec;
    logic [NUM_DIGITS-1:0] w_blank;
    logic                  w_upper_zero;

    assign w_tc        = (r_prescaler == PS_W'(REFRESH_DIV - 1));
    assign w_wrap      = w_tc && (r_index == IDX_W'(NUM_DIGITS - 1));
    assign w_sel_digit = r_disp[BCD_W*r_index +: BCD_W];

    bcd_to_seg7 u_dec (
        .i_bcd (w_sel_digit),
        .o_seg (w_seg_dec)
    );

    // A digit is blanked only when it and every more-significant digit are zero.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_upper_zero = 1'b1;
        w_blank      = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_upper_zero = w_upper_zero && (r_disp[BCD_W*i +: BCD_W] == '0);
            w_blank[i]   = blank_lz && w_upper_zero;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prescaler <= '0;
            r_index     <= '0;
            r_shadow    <= '0;
            r_disp      <= '0;
        end else begin
            r_prescaler <= w_tc ? '0 : r_prescaler + 1'b1;
            if (w_tc) begin
                r_index <= (r_index == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_index + 1'b1;
            end
            if (load) begin
                r_shadow <= digits_in;
            end
            // Disp only moves on the frame wrap, so it picks up the pre-edge shadow.
            if (w_wrap) begin
                r_disp <= r_shadow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_seg        <= SEG_BLANK;
            r_an         <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= NUM_DIGITS'(1) << r_index;
            r_seg        <= w_blank[r_index] ? SEG_BLANK : w_seg_dec;
            r_frame_done <= w_wrap;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Downstream consumer of the team's 4-bit BCD decade counters.
- Takes NUM_DIGITS packed BCD digits and time-multiplexes them onto one shared 7-segment bus with one-hot digit enables.
- Features: tear-free frame snapshot, leading-zero blanking, invalid-code indication, and a per-frame strobe for the bench and higher-level logic.

Parameters:
- NUM_DIGITS, 4: number of BCD digits scanned; legal range 2..8.
- REFRESH_DIV, 4: clock cycles each digit stays lit; legal minimum 2. Silicon builds override with a large value; sim uses 4.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- reset  input  1  synchronous, active-low reset; 0 sampled at a rising edge resets the block.
- digits_in  input  4*NUM_DIGITS  packed BCD; digit i is bits [4i+3:4i]; digit 0 is least significant.
- load  input  1  when 1 at a rising edge, digits_in is captured into the shadow register.
- blank_lz  input  1  1 enables leading-zero blanking.
- seg  output  7  segment drive, order {g,f,e,d,c,b,a}; active-high; registered.
- an  output  NUM_DIGITS  one-hot digit enable, active-high; bit i lights digit i; registered.
- frame_done  output  1  one-cycle pulse when the last digit slot of a frame ends; registered.

Behaviour:
- **Reset** (reset=0 at an edge): prescaler=0, index=0, shadow=0, disp=0, seg=0, an=0, frame_done=0. Reset is honoured mid-frame; no partial state survives.
- **Prescaler**: counts 0..REFRESH_DIV-1 and wraps.
  - Terminal count (tc) = prescaler==REFRESH_DIV-1.
  - On tc, index advances; index wraps from NUM_DIGITS-1 to 0.
- **Shadow**: shadow<=digits_in on every edge with load=1, independent of scan position.
- **Display register**:
  - disp<=shadow on the edge where tc=1 and index==NUM_DIGITS-1 (frame wrap).
  - If load=1 on that same edge, disp takes the OLD shadow; the new value shows from the following frame.
  - disp changes nowhere else, so a frame is never torn.
- **Outputs** are registered from the current index and disp, so they lag index by one cycle.
  - an<=(1<<index).
  - seg<=decode(disp digit[index]), or 0 if that digit is blanked.
  - First edge after reset release: an=0001, seg=7'h3F (disp=0).
  - Each digit is then shown for exactly REFRESH_DIV cycles; the full frame is NUM_DIGITS*REFRESH_DIV cycles.
- **Decode** (gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10..15 display 40 (dash, segment g only).
- **Leading-zero blanking**:
  - Digit i (i>=1) is blanked when blank_lz=1, disp digit i==0, and every digit above i is 0.
  - Digit 0 is never blanked.
  - Blanking is evaluated combinationally from disp.
  - A blanked digit keeps its an bit set and only drives seg=0, so scan timing is unchanged.
  - blank_lz is sampled live each cycle, not frame-latched.
- **frame_done**: frame_done<=1 on the edge where tc=1 and index==NUM_DIGITS-1; 0 otherwise. It is therefore high during the first cycle of digit 0's slot in the next frame's index, i.e. the cycle disp has just updated.
- **Invariant**: an is never multi-hot; an is 0 only during reset and the cycle immediately following it.

Decomposition:
- Package bcd_pkg:
  - localparams SEG_0..SEG_9, SEG_DASH=7'h40, SEG_BLANK=7'h00.
  - BCD_W=4.
  - Function bcd_to_seg(input [3:0]) returning [6:0].
- Sub-module bcd_to_seg7: purely combinational decoder wrapping the package function. It is reusable by other display blocks; instantiate it once on the selected digit.
- Prescaler, index, shadow/disp and output registers stay in bcd_scan_display.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4):
1. **Reset and first frame**: reset=0 for 3 edges, then 1 -> seg=00, an=0000 during reset.
   - First edge after release: an=0001, seg=3F.
   - an then steps 0001,0010,0100,1000, 4 cycles each.
   - frame_done pulses once every 16 cycles.
2. **Load and snapshot**: load=1 one cycle with digits_in=16'h1234 mid-frame.
   - Current frame still shows 0s.
   - Next frame: an=0001 seg=66 (4), 0010 seg=4F (3), 0100 seg=5B (2), 1000 seg=06 (1).
3. **Leading-zero blanking**: digits_in=16'h0070, blank_lz=1 -> digit3 and digit2 seg=00; digit1 seg=07; digit0 seg=3F.
   - Same data with blank_lz=0 -> seg=3F,3F,07,3F.
   - digits_in=16'h0000 with blank_lz=1 -> only digit0 lit, seg=3F.
4. **Invalid code**: digits_in=16'h9AF0 -> digit3 6F, digit2 40, digit1 40, digit0 3F.
5. **Load on the wrap edge**: load=1 with 16'h5555 on the exact frame_done-generating edge, shadow previously 16'h1111.
   - Next frame shows all 06.
   - The frame after shows all 6D.
6. **Mid-frame reset**: assert reset during the digit2 slot with disp=16'h8888.
   - At the reset edge: seg=00, an=0000.
   - After release, display restarts at digit0 showing 3F; shadow and disp are cleared, so the old 8s never reappear.
   - No frame_done until 16 cycles after release.
